// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and datapath select encodings
// for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_MEM,
    WB_ALU,
    BRANCH
  } state_t;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RFN = 2'b10;
  localparam logic [1:0] ALUOP_IFN = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_OFF  = 2'b11;

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter; wraps silently at 2^W.
module retire_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   count <= '0;
    else if (en) count <= count + W'(1);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the shared-ALU, shared-memory datapath controls.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W     = 7,
  parameter int unsigned ALUOP_W      = 2,
  parameter int unsigned CNT_W        = 32,
  parameter bit          ENABLE_ITYPE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic                PCSrc,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                IllegalOp,
  output logic [CNT_W-1:0]    RetiredCount
);

  state_t state, state_d;
  logic   retire_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_d;
  end

  // Next state and controls; everything is held at 0 while reset is high.
  always_comb begin
    state_d     = state;
    retire_en   = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    PCSrc       = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_W'(ALUOP_ADD);
    IllegalOp   = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          ALUSrcB = SRCB_OFF;
          if (Opcode == OPCODE_W'(OP_RTYPE))                       state_d = EXEC_R;
          else if (ENABLE_ITYPE && Opcode == OPCODE_W'(OP_ITYPE))  state_d = EXEC_I;
          else if (Opcode == OPCODE_W'(OP_LOAD) ||
                   Opcode == OPCODE_W'(OP_STORE))                  state_d = MEM_ADDR;
          else if (Opcode == OPCODE_W'(OP_BRANCH))                 state_d = BRANCH;
          else begin
            IllegalOp = 1'b1;
            state_d   = FETCH;
          end
        end
        EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_REG;
          ALUOp   = ALUOP_W'(ALUOP_RFN);
          state_d = WB_ALU;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_W'(ALUOP_IFN);
          state_d = WB_ALU;
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = (Opcode == OPCODE_W'(OP_STORE)) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_d = WB_MEM;
        end
        MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) begin
            retire_en = 1'b1;
            state_d   = FETCH;
          end
        end
        WB_MEM: begin
          RegWrite  = 1'b1;
          MemtoReg  = 1'b1;
          retire_en = 1'b1;
          state_d   = FETCH;
        end
        WB_ALU: begin
          RegWrite  = 1'b1;
          retire_en = 1'b1;
          state_d   = FETCH;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = SRCB_REG;
          ALUOp       = ALUOP_W'(ALUOP_SUB);
          PCWriteCond = 1'b1;
          PCSrc       = 1'b1;
          retire_en   = 1'b1;
          state_d     = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  retire_counter #(.W(CNT_W)) u_retire (
    .clk   (clk),
    .reset (reset),
    .en    (retire_en),
    .count (RetiredCount)
  );

endmodule
